// File: rtl/regfile_arbiter_pkg.sv
// regfile_arbiter_pkg
//   Shared defaults and helpers for the register-file arbiter slice.
//   ARB_DATA_W / ARB_ADDR_W / ARB_N_REQ : default data width, address width,
//                                         requester count
//   owner_w(n)                          : owner-id width, clog2(n), min 1
package regfile_arbiter_pkg;

  localparam int unsigned ARB_DATA_W = 8;
  localparam int unsigned ARB_ADDR_W = 2;
  localparam int unsigned ARB_N_REQ  = 2;

  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// rr_pick
//   Combinational one-of-N picker used for both the write and read side.
//   Optional feature macro: REGFILE_ARB_RR_EN
//     defined     : round-robin, search starts at ptr and wraps upward;
//                   next_ptr is the winner + 1 mod N (ptr unchanged if no req)
//     not defined : fixed priority, lowest index wins; no pointer ports
//   Ports:
//     req      in  N            request vector
//     ptr      in  owner_w(N)   current priority pointer (RR build only)
//     next_ptr out owner_w(N)   pointer to load after a grant (RR build only)
//     grant    out N            one-hot grant (all zero when no request)
module rr_pick
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned N = ARB_N_REQ
) (
  input  logic [N-1:0]            req,
`ifdef REGFILE_ARB_RR_EN
  input  logic [owner_w(N)-1:0]   ptr,
  output logic [owner_w(N)-1:0]   next_ptr,
`endif
  output logic [N-1:0]            grant
);

`ifdef REGFILE_ARB_RR_EN
  localparam int unsigned IW = owner_w(N);

  // Two passes instead of a rotated index: first the requesters at or above
  // the pointer, then the wrapped-around ones below it.
  always_comb begin
    logic found;
    found    = 1'b0;
    grant    = '0;
    next_ptr = ptr;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req[j] && (32'(ptr) <= j)) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        next_ptr = (j == N - 1) ? '0 : IW'(j + 1);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req[j] && (j < 32'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        next_ptr = (j == N - 1) ? '0 : IW'(j + 1);
      end
    end
  end
`else
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares the single write / single read port pair of the register file
//   between N_REQ requesters. Writes and reads are arbitrated independently;
//   a read whose winning address equals the winning write address in the
//   same cycle is held back one cycle so it observes the new data.
//   Optional feature macro: REGFILE_ARB_RR_EN (round-robin pointers; without
//   it, fixed priority with the lowest index winning).
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     req_valid/we         per-requester valid and write(1)/read(0) select
//     req_adr/req_wdata    packed per-requester address and write data
//     req_ready            grant, transfer on valid&ready
//     rsp_valid/rsp_data   one-hot read-response pulse and shared read data
//     w_en/w_adr/w_data    register-file write port (registered)
//     r_en/r_adr           register-file read port (registered)
//     r_data               register-file read data, valid cycle after r_en
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = ARB_N_REQ,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned ADDR_W = ARB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_adr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     w_en,
  output logic [ADDR_W-1:0]        w_adr,
  output logic [DATA_W-1:0]        w_data,
  output logic                     r_en,
  output logic [ADDR_W-1:0]        r_adr,
  input  logic [DATA_W-1:0]        r_data
);

  localparam int unsigned ID_W = owner_w(N_REQ);

  logic [N_REQ-1:0]  w_req, r_req;
  logic [N_REQ-1:0]  w_grant, r_pick_grant, r_grant;
  logic              w_any, r_any, collide;
  logic [ADDR_W-1:0] w_sel_adr, r_sel_adr;
  logic [DATA_W-1:0] w_sel_data;
  logic [ID_W-1:0]   r_id, rsp_owner;
  logic [N_REQ-1:0]  rsp_onehot;

  // Requests are masked during reset so req_ready reads 0 there.
  assign w_req = rst ? '0 : (req_valid &  req_we);
  assign r_req = rst ? '0 : (req_valid & ~req_we);

`ifdef REGFILE_ARB_RR_EN
  logic [ID_W-1:0] w_ptr, r_ptr, w_ptr_nxt, r_ptr_nxt;

  rr_pick #(.N(N_REQ)) u_w_pick (
    .req      (w_req),
    .ptr      (w_ptr),
    .next_ptr (w_ptr_nxt),
    .grant    (w_grant)
  );

  rr_pick #(.N(N_REQ)) u_r_pick (
    .req      (r_req),
    .ptr      (r_ptr),
    .next_ptr (r_ptr_nxt),
    .grant    (r_pick_grant)
  );
`else
  rr_pick #(.N(N_REQ)) u_w_pick (
    .req   (w_req),
    .grant (w_grant)
  );

  rr_pick #(.N(N_REQ)) u_r_pick (
    .req   (r_req),
    .grant (r_pick_grant)
  );
`endif

  // Winner address/data/id muxes driven from the one-hot grants.
  always_comb begin
    w_sel_adr  = '0;
    w_sel_data = '0;
    r_sel_adr  = '0;
    r_id       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_adr  = req_adr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_wdata[i*DATA_W +: DATA_W];
      end
      if (r_pick_grant[i]) begin
        r_sel_adr = req_adr[i*ADDR_W +: ADDR_W];
        r_id      = ID_W'(i);
      end
    end
  end

  assign w_any     = |w_grant;
  assign r_any     = |r_pick_grant;
  assign collide   = w_any & r_any & (w_sel_adr == r_sel_adr);
  assign r_grant   = collide ? '0 : r_pick_grant;
  assign req_ready = w_grant | r_grant;

  always_comb begin
    rsp_onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_onehot[i] = (32'(rsp_owner) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en      <= 1'b0;
      w_adr     <= '0;
      w_data    <= '0;
      r_en      <= 1'b0;
      r_adr     <= '0;
      rsp_owner <= '0;
      rsp_valid <= '0;
`ifdef REGFILE_ARB_RR_EN
      w_ptr     <= '0;
      r_ptr     <= '0;
`endif
    end else begin
      w_en <= w_any;
      if (w_any) begin
        w_adr  <= w_sel_adr;
        w_data <= w_sel_data;
      end
      r_en <= r_any & ~collide;
      if (r_any && !collide) begin
        r_adr     <= r_sel_adr;
        rsp_owner <= r_id;
      end
      rsp_valid <= r_en ? rsp_onehot : '0;
`ifdef REGFILE_ARB_RR_EN
      if (w_any) w_ptr <= w_ptr_nxt;
      // A collided read keeps its pointer so it wins again next cycle.
      if (r_any && !collide) r_ptr <= r_ptr_nxt;
`endif
    end
  end

  // r_data is already registered by the register file; only qualify it.
  assign rsp_data = (|rsp_valid) ? r_data : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
//   Directed bench for regfile_arbiter with a behavioural 4x8 register file
//   (registered read). Table of combinational grant vectors plus hand-written
//   multi-cycle sequences.
module tb_regfile_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_we;
  logic [3:0] req_adr;
  logic [15:0] req_wdata;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       w_en;
  logic [1:0] w_adr;
  logic [7:0] w_data;
  logic       r_en;
  logic [1:0] r_adr;
  logic [7:0] r_data;

  logic [7:0] mem [4];

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_arbiter #(.N_REQ(2), .DATA_W(8), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .w_en      (w_en),
    .w_adr     (w_adr),
    .w_data    (w_data),
    .r_en      (r_en),
    .r_adr     (r_adr),
    .r_data    (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous write, registered read.
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    r_data = 8'h00;
  end
  always @(posedge clk) begin
    if (w_en) mem[w_adr] <= w_data;
    if (r_en) r_data <= mem[r_adr];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int id, input logic [1:0] a, input logic [7:0] d);
    int n;
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    req_we[id] = 1'b1;
    req_adr[id*2 +: 2] = a;
    req_wdata[id*8 +: 8] = d;
    #1;
    n = 0;
    while (!req_ready[id] && n < 10) begin
      step();
      n++;
    end
    chk("preload_grant", 32'(req_ready[id]), 32'd1);
    step();
    req_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic [3:0] adr;
    logic [1:0] ready;
  } vec_t;

  vec_t tbl [10];
  logic [1:0] exp_rr;

  initial begin
    // adr field is {requester1, requester0}
    tbl[0] = '{2'b00, 2'b00, 4'h0, 2'b00};
    tbl[1] = '{2'b01, 2'b01, 4'h0, 2'b01};
    tbl[2] = '{2'b11, 2'b11, 4'h4, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 4'h4, 2'b01};
    tbl[4] = '{2'b11, 2'b01, 4'h4, 2'b11};
    tbl[5] = '{2'b11, 2'b01, 4'hA, 2'b01};
    tbl[6] = '{2'b10, 2'b00, 4'h8, 2'b10};
    tbl[7] = '{2'b11, 2'b10, 4'hF, 2'b10};
    tbl[8] = '{2'b10, 2'b10, 4'hC, 2'b10};
    tbl[9] = '{2'b11, 2'b10, 4'hD, 2'b11};

    // ---- reset with all requests valid ----
    rst = 1'b1;
    req_valid = 2'b11;
    req_we = 2'b11;
    req_adr = 4'h4;
    req_wdata = 16'h2211;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_w_adr", 32'(w_adr), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_r_adr", 32'(r_adr), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'd1);
    #1;
    req_valid = 2'b00;
    step();

    // ---- combinational grant table (valid dropped before each edge) ----
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid;
      req_we    = tbl[i].we;
      req_adr   = tbl[i].adr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      #1;
      req_valid = 2'b00;
      step();
    end

    // ---- both requesters write continuously ----
    req_valid = 2'b11;
    req_we = 2'b11;
    req_adr = 4'h4;
    req_wdata = 16'h2211;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_RR_EN
      exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_rr = 2'b01;
`endif
      chk($sformatf("arb_ready%0d", k), 32'(req_ready), 32'(exp_rr));
      step();
      if (k == 0) chk("arb_first_wdata", 32'(w_data), 32'h11);
    end
    req_valid = 2'b00;
    step();
    step();

    // ---- write then read same address ----
    req_valid = 2'b01;
    req_we = 2'b01;
    req_adr = 4'h0;
    req_wdata = 16'h008E;
    #1;
    chk("wr_ready", 32'(req_ready), 32'd1);
    step();
    chk("wr_w_en", 32'(w_en), 32'd1);
    chk("wr_w_data", 32'(w_data), 32'h8E);
    req_we = 2'b00;
    #1;
    chk("rd_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b00;
    chk("rd_r_en", 32'(r_en), 32'd1);
    chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
    step();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'h8E);
    step();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);

    // ---- concurrent write adr3 / read adr2 ----
    do_write(0, 2'd2, 8'h8C);
    step();
    req_valid = 2'b11;
    req_we = 2'b01;
    req_adr = {2'd2, 2'd3};
    req_wdata = 16'h00BE;
    #1;
    chk("conc_ready", 32'(req_ready), 32'd3);
    step();
    req_valid = 2'b00;
    chk("conc_w_en", 32'(w_en), 32'd1);
    chk("conc_r_en", 32'(r_en), 32'd1);
    chk("conc_r_adr", 32'(r_adr), 32'd2);
    step();
    chk("conc_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("conc_rsp_data", 32'(rsp_data), 32'h8C);
    step();

    // ---- collision: write 55 to adr2 while reading adr2 ----
    req_valid = 2'b11;
    req_we = 2'b01;
    req_adr = {2'd2, 2'd2};
    req_wdata = 16'h0055;
    #1;
    chk("col_ready_t", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b10;
    #1;
    chk("col_w_en", 32'(w_en), 32'd1);
    chk("col_r_en_stall", 32'(r_en), 32'd0);
    chk("col_ready_t1", 32'(req_ready), 32'd2);
    step();
    req_valid = 2'b00;
    chk("col_r_en", 32'(r_en), 32'd1);
    chk("col_rsp_early", 32'(rsp_valid), 32'd0);
    step();
    chk("col_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("col_rsp_data", 32'(rsp_data), 32'h55);
    step();

    // ---- reset the cycle after a read handshake ----
    req_valid = 2'b10;
    req_we = 2'b00;
    req_adr = {2'd3, 2'd0};
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    chk("mrst_r_en", 32'(r_en), 32'd1);
    step();
    rst = 1'b0;
    chk("mrst_r_en_cleared", 32'(r_en), 32'd0);
    chk("mrst_rsp0", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mrst_rsp%0d", k + 1), 32'(rsp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-write/single-read port pair of the 4×8 register file between `N_REQ` requesters, for example the weight loader and the MAC engine. Writes and reads are arbitrated independently, so one write and one read can be issued per cycle. Same-cycle read-after-write collisions are resolved by deferring the read. The block sits between the compute requesters and `register`, and drives all of that module's ports.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2–8)
- `DATA_W`, 8, register data width
- `ADDR_W`, 2, register address width (4 entries)

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  request pending, per requester
- `req_we`  in  N_REQ  1 = write request, 0 = read request
- `req_adr`  in  N_REQ*ADDR_W  request address, requester i at slice [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  N_REQ*DATA_W  write data, same slicing
- `req_ready`  out  N_REQ  grant; a request transfers when valid&ready
- `rsp_valid`  out  N_REQ  one-cycle pulse, read data valid for requester i
- `rsp_data`  out  DATA_W  read data, shared by all requesters, qualified by `rsp_valid`
- `w_en`, `w_adr`, `w_data`  out  1/ADDR_W/DATA_W  register-file write port
- `r_en`, `r_adr`  out  1/ADDR_W  register-file read port
- `r_data`  in  DATA_W  register-file read data, registered: valid the cycle after `r_en`

## Operation
- Write arbiter: among requesters with `req_valid & req_we`, grant exactly one per cycle.
- Read arbiter: among requesters with `req_valid & ~req_we`, grant exactly one per cycle, independent of the write arbiter.
- Round-robin priority: each arbiter keeps its own pointer. After a grant to requester i, the pointer moves to i+1 mod `N_REQ`. Priority starts at the pointer and proceeds upward with wrap-around.
- `req_ready` is combinational from `req_valid`, `req_we`, `req_adr` and the pointers. Requesters must hold their request stable until it is granted.
- Collision rule: if the winning read's address equals the winning write's address in the same cycle, the read is not granted. Its pointer does not move, and it retries next cycle, when it sees the new data.
- Register stage: a granted write drives `w_en`/`w_adr`/`w_data` in the next cycle. A granted read drives `r_en`/`r_adr` in the next cycle and records the owner id in a response pipeline register.
- Response: the cycle after `r_en`, `rsp_data` equals `r_data` and the owner's `rsp_valid` bit is set. At most one `rsp_valid` bit is high in any cycle.
- Reset values:
  - all outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `w_en`, `w_adr`, `w_data`, `r_en`, `r_adr`
  - both pointers 0
- Reset mid-operation: in-flight writes and reads are dropped. No `rsp_valid` is produced for reads that were accepted before reset.

## Timing
- Write: handshake in cycle t → `w_en`=1 in t+1 → data is readable by a read handshaken in t+1 or later.
- Read: handshake in cycle t → `r_en`=1 in t+1 → `rsp_valid`/`rsp_data` in t+2. Latency is fixed at 2 cycles.
- Throughput: 1 write + 1 read per cycle, with no bubbles except on collisions.
- A collision costs exactly one cycle of read stall.
- `w_en`/`r_en` are low in any cycle not preceded by a grant.

## Configuration
- `REGFILE_ARB_RR_EN` defined: round-robin pointers as described above.
- Not defined: fixed priority, with the lowest index winning. Pointer registers are removed and the collision rule is unchanged.

## Structure
- Shared package/header holds:
  - `ARB_DATA_W`, `ARB_ADDR_W`, `ARB_N_REQ` defaults
  - the owner-id width, computed as clog2(`N_REQ`)
- One sub-module, `rr_pick`, is instantiated twice (write side and read side). It takes a request vector and a pointer, and returns a one-hot grant plus the next pointer. It is combinational apart from the pointer register, which is held in the parent.

## Test plan
- Reset: hold `rst` 2 cycles with all requests valid → all outputs 0; first grant after release goes to requester 0.
- Write then read:
  - stimulus: requester 0 writes 8'h8E to adr 0 in cycle t, reads adr 0 in t+1
  - required: `w_en` in t+1; `rsp_valid`[0]=1 with `rsp_data`=8'h8E in t+3
- Round-robin: both requesters write continuously → `req_ready` alternates 01,10,01,…; the fixed-priority build always grants 01.
- Concurrent read/write:
  - stimulus: requester 0 writes 8'hBE to adr 3 while requester 1 reads adr 2 (holding 8'h8C), both in cycle t
  - required: both granted in t; `rsp_valid`[1] with 8'h8C in t+2
- Collision:
  - stimulus: adr 2 holds 8'h8C; requester 0 writes 8'h55 to adr 2 while requester 1 reads adr 2
  - required: read granted one cycle late; `rsp_data`=8'h55
- Reset mid-read: assert `rst` the cycle after a read handshake → no `rsp_valid` ever appears for that read.
